// File: rtl/alu_pipe_if.sv
// Valid/ready bundle between the sequencer and the two-stage ALU pipe.
// The opcode type is a parameter so the interface does not depend on any package.
interface alu_pipe_if #(
    parameter int  WIDTH = 8,
    parameter type op_t  = logic [2:0]
);
    logic             in_valid;
    logic             in_ready;
    op_t              opcode;
    logic [WIDTH-1:0] accum;
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             res_zero;
    logic             busy;

    modport master (
        output in_valid, opcode, accum, data, out_ready,
        input  in_ready, zero, out_valid, out, carry, res_zero, busy
    );

    modport slave (
        input  in_valid, opcode, accum, data, out_ready,
        output in_ready, zero, out_valid, out, carry, res_zero, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage accumulator ALU: S1 captures operands, S2 holds the result.
// Stages advance independently under valid/ready backpressure.
package cpu_rtl_pkg;
    typedef enum logic [2:0] {HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP} opcode_t;
endpackage

module alu_pipe
    import cpu_rtl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_,
    alu_pipe_if.slave bus
);
    logic             r_s1_v;
    opcode_t          r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_d;

    logic             r_s2_v;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic             r_rz;

    logic             w_adv1;
    logic             w_adv2;
    opcode_t          w_op;
    logic [WIDTH:0]   w_res;

    assign w_op   = opcode_t'(bus.opcode);
    assign w_adv2 = !r_s2_v || bus.out_ready;
    assign w_adv1 = !r_s1_v || w_adv2;

    assign bus.in_ready  = w_adv1 && rst_;
    assign bus.zero      = ~|bus.accum;
    assign bus.out_valid = r_s2_v;
    assign bus.out       = r_out;
    assign bus.carry     = r_carry;
    assign bus.res_zero  = r_rz;
    assign bus.busy      = r_s1_v || r_s2_v;

    // Bit WIDTH of w_res is the carry; only ADD can set it.
    always_comb begin
        w_res = {1'b0, r_s1_a};
        unique case (r_s1_op)
            ADD:     w_res = {1'b0, r_s1_a} + {1'b0, r_s1_d};
            AND:     w_res = {1'b0, r_s1_a & r_s1_d};
            XOR:     w_res = {1'b0, r_s1_a ^ r_s1_d};
            LDA:     w_res = {1'b0, r_s1_d};
            default: w_res = {1'b0, r_s1_a};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_s1_v  <= 1'b0;
            r_s1_op <= HLT;
            r_s1_a  <= '0;
            r_s1_d  <= '0;
            r_s2_v  <= 1'b0;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_rz    <= 1'b1;
        end else begin
            if (w_adv1) begin
                r_s1_v <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_op <= w_op;
                    r_s1_a  <= bus.accum;
                    r_s1_d  <= bus.data;
                end
            end
            // A bubble in S1 still advances, clearing S2's valid bit.
            if (w_adv2) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_out   <= w_res[WIDTH-1:0];
                    r_carry <= w_res[WIDTH];
                    r_rz    <= ~|w_res[WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed cases plus a random valid/ready stress.
// A 16-bit instance covers the wide carry and pass-through cases.
module tb_alu_pipe;
    import cpu_rtl_pkg::*;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(8),  .op_t(opcode_t)) b8  ();
    alu_pipe_if #(.WIDTH(16), .op_t(opcode_t)) b16 ();

    alu_pipe #(.WIDTH(8))  u8  (.clk(clk), .rst_(rst_), .bus(b8));
    alu_pipe #(.WIDTH(16)) u16 (.clk(clk), .rst_(rst_), .bus(b16));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: {carry, result} straight from the opcode definitions.
    function automatic logic [8:0] model(opcode_t op, logic [7:0] a, logic [7:0] d);
        int s;
        case (op)
            ADD: begin
                s = int'(a) + int'(d);
                return s[8:0];
            end
            AND:     return {1'b0, a & d};
            XOR:     return {1'b0, a ^ d};
            LDA:     return {1'b0, d};
            default: return {1'b0, a};
        endcase
    endfunction

    logic [8:0] q[$];
    logic [8:0] exp_v;
    logic [9:0] held;
    bit         stalled = 0;

    always @(negedge clk) begin
        if (!rst_) begin
            q.delete();
            stalled = 0;
        end else begin
            if (stalled && b8.out_valid)
                chk("stall_hold", {b8.carry, b8.res_zero, b8.out}, held);
            if (b8.out_valid && b8.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", {b8.carry, b8.out}, 9'h1ff);
                end else begin
                    exp_v = q.pop_front();
                    chk("out", b8.out, exp_v[7:0]);
                    chk("carry", b8.carry, exp_v[8]);
                    chk("res_zero", b8.res_zero, exp_v[7:0] == 8'h00);
                end
            end
            stalled = b8.out_valid && !b8.out_ready;
            held    = {b8.carry, b8.res_zero, b8.out};
            if (b8.in_valid && b8.in_ready)
                q.push_back(model(b8.opcode, b8.accum, b8.data));
        end
    end

    task automatic issue(opcode_t op, logic [7:0] a, logic [7:0] d);
        bit ok = 0;
        b8.in_valid = 1'b1;
        b8.opcode   = op;
        b8.accum    = a;
        b8.data     = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = b8.in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("issue_timeout", 0, 1);
        b8.in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        b8.in_valid   = 0; b8.opcode  = HLT; b8.accum  = 0; b8.data  = 0;
        b8.out_ready  = 1;
        b16.in_valid  = 0; b16.opcode = HLT; b16.accum = 0; b16.data = 0;
        b16.out_ready = 1;

        // Reset state
        tick(); tick();
        chk("rst_in_ready", b8.in_ready, 0);
        chk("rst_out_valid", b8.out_valid, 0);
        chk("rst_busy", b8.busy, 0);
        chk("rst_out", b8.out, 0);
        chk("rst_res_zero", b8.res_zero, 1);

        // First transfer on first edge out of reset; result two edges after offer
        rst_ = 1;
        b8.in_valid = 1; b8.opcode = ADD; b8.accum = 8'hF0; b8.data = 8'h20;
        @(negedge clk);
        chk("first_in_ready", b8.in_ready, 1);
        tick();
        b8.in_valid = 0;
        chk("lat_not_yet", b8.out_valid, 0);
        tick();
        chk("lat_valid", b8.out_valid, 1);
        chk("lat_out", b8.out, 8'h10);
        chk("lat_carry", b8.carry, 1);
        chk("lat_res_zero", b8.res_zero, 0);

        // XOR to zero; zero flag follows live accum only
        issue(XOR, 8'h5A, 8'h5A);
        b8.accum = 8'h5A;
        #1 chk("zero_live0", b8.zero, 0);
        b8.accum = 8'h00;
        #1 chk("zero_live1", b8.zero, 1);
        tick(); tick();
        chk("xor_out", b8.out, 8'h00);
        chk("xor_rz", b8.res_zero, 1);

        // Backpressure: two accepts fill the pipe, then in_ready drops
        b8.out_ready = 0;
        issue(LDA, 8'h00, 8'h01);
        issue(LDA, 8'h00, 8'h02);
        b8.in_valid = 1; b8.opcode = LDA; b8.data = 8'h03;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_in_ready", b8.in_ready, 0);
            chk("full_out", b8.out, 8'h01);
            chk("full_busy", b8.busy, 1);
            tick();
        end
        b8.out_ready = 1;
        issue(LDA, 8'h00, 8'h03);
        issue(LDA, 8'h00, 8'h04);
        tick(); tick(); tick();

        // Reset with both stages valid discards everything
        b8.out_ready = 0;
        issue(LDA, 8'h00, 8'hAA);
        issue(ADD, 8'h11, 8'h22);
        chk("pre_rst_busy", b8.busy, 1);
        rst_ = 0;
        tick();
        chk("mid_rst_valid", b8.out_valid, 0);
        chk("mid_rst_busy", b8.busy, 0);
        chk("mid_rst_out", b8.out, 0);
        chk("mid_rst_rz", b8.res_zero, 1);
        chk("mid_rst_carry", b8.carry, 0);
        chk("mid_rst_in_ready", b8.in_ready, 0);
        rst_ = 1;
        b8.out_ready = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("post_rst_busy", b8.busy, 0);

        // 16-bit: wrap-around carry, then pass-through
        b16.in_valid = 1; b16.opcode = ADD; b16.accum = 16'hFFFF; b16.data = 16'h0001;
        @(negedge clk);
        chk("w16_in_ready", b16.in_ready, 1);
        tick();
        b16.opcode = STO; b16.accum = 16'h1234; b16.data = 16'hBEEF;
        tick();
        b16.in_valid = 0;
        chk("w16_add_valid", b16.out_valid, 1);
        chk("w16_add_out", b16.out, 16'h0000);
        chk("w16_add_carry", b16.carry, 1);
        chk("w16_add_rz", b16.res_zero, 1);
        tick();
        chk("w16_sto_out", b16.out, 16'h1234);
        chk("w16_sto_carry", b16.carry, 0);
        chk("w16_sto_rz", b16.res_zero, 0);

        // Random valid/ready stress
        sent = 0;
        for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
            b8.in_valid  = ($urandom_range(0, 9) < 7);
            b8.opcode    = opcode_t'($urandom_range(0, 7));
            b8.accum     = 8'($urandom);
            b8.data      = ($urandom_range(0, 7) == 0) ? b8.accum : 8'($urandom);
            b8.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (b8.in_valid && b8.in_ready) sent++;
            tick();
        end
        chk("stress_sent", sent, 10000);
        b8.in_valid  = 0;
        b8.out_ready = 1;
        for (int i = 0; i < 20 && b8.busy; i++) tick();
        tick();
        chk("drain_busy", b8.busy, 0);
        chk("drain_queue", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
